// File: rtl/planificador_booth.sv
// Round-robin arbiter and sequencer for the shared radix-2 Booth multiplier datapath.
// Two clients compete for the datapath; the winner's operation runs LOAD, then N EVAL/SHIFT pairs, then DONE.
module planificador_booth #(
   parameter int N = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic req0,
   input  logic req1,
   input  logic q0,
   input  logic qsub1,
   output logic gnt0,
   output logic gnt1,
   output logic sel,
   output logic busy,
   output logic CargaQ,
   output logic CargaM,
   output logic ResetA,
   output logic CargaA,
   output logic Resta,
   output logic DesplazaAQ,
   output logic done0,
   output logic done1
);

   localparam int CW = $clog2(N + 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LOAD  = 3'd1;
   localparam logic [2:0] EVAL  = 3'd2;
   localparam logic [2:0] SHIFT = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic          last;
   logic          pick;

   // With both clients waiting, the one not served last time wins
   always_comb begin
      pick = 1'b0;
      if (req0 && req1) begin
         pick = ~last;
      end else if (req1) begin
         pick = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         sel   <= 1'b0;
         last  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  sel   <= pick;
                  last  <= pick;
                  cnt   <= CW'(N);
                  state <= LOAD;
               end
            end
            LOAD:  state <= EVAL;
            EVAL:  state <= SHIFT;
            SHIFT: begin
               cnt   <= cnt - CW'(1);
               state <= (cnt == CW'(1)) ? DONE : EVAL;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Strobes are pure state decodes; only EVAL looks at the Booth bit pair
   always_comb begin
      CargaQ     = 1'b0;
      CargaM     = 1'b0;
      ResetA     = 1'b0;
      CargaA     = 1'b0;
      Resta      = 1'b0;
      DesplazaAQ = 1'b0;
      done0      = 1'b0;
      done1      = 1'b0;
      case (state)
         LOAD: begin
            CargaQ = 1'b1;
            CargaM = 1'b1;
            ResetA = 1'b1;
         end
         EVAL: begin
            CargaA = q0 ^ qsub1;
            Resta  = q0 & ~qsub1;
         end
         SHIFT: DesplazaAQ = 1'b1;
         DONE: begin
            done0 = ~sel;
            done1 = sel;
         end
         default: ;
      endcase
   end

   assign busy = (state != IDLE);
   assign gnt0 = busy & ~sel;
   assign gnt1 = busy & sel;

endmodule

// File: tb/tb_planificador_booth.sv
// Directed bench for planificador_booth: N=4 and N=8 instances driving behavioural Booth datapaths.
module tb_planificador_booth;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   // N=4 instance
   logic req0 = 1'b0, req1 = 1'b0, q0, qsub1;
   logic gnt0, gnt1, sel, busy, cargaq, cargam, reseta, cargaa, resta, desplaza, done0, done1;
   logic usemodel = 1'b1, fq0 = 1'b0, fqs = 1'b0;
   logic [4:0] a4 = '0, m4 = '0;
   logic [3:0] qr4 = '0;
   logic       qm4 = 1'b0;
   logic [3:0] opm0 = '0, opq0 = '0, opm1 = '0, opq1 = '0;

   // N=8 instance
   logic r80 = 1'b0, r81 = 1'b0, q80, qs81;
   logic g80, g81, sel8, busy8, cq8, cm8, ra8, ca8, rs8, dz8, d80, d81;
   logic [8:0] a8 = '0, m8 = '0;
   logic [7:0] qr8 = '0;
   logic       qm8 = 1'b0;

   int total = 0;
   int bad = 0;
   int overlap = 0;

   planificador_booth #(.N(4)) dut (
      .clk(clk), .reset(reset), .req0(req0), .req1(req1), .q0(q0), .qsub1(qsub1),
      .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .busy(busy), .CargaQ(cargaq), .CargaM(cargam),
      .ResetA(reseta), .CargaA(cargaa), .Resta(resta), .DesplazaAQ(desplaza),
      .done0(done0), .done1(done1));

   planificador_booth #(.N(8)) dut8 (
      .clk(clk), .reset(reset), .req0(r80), .req1(r81), .q0(q80), .qsub1(qs81),
      .gnt0(g80), .gnt1(g81), .sel(sel8), .busy(busy8), .CargaQ(cq8), .CargaM(cm8),
      .ResetA(ra8), .CargaA(ca8), .Resta(rs8), .DesplazaAQ(dz8),
      .done0(d80), .done1(d81));

   assign q0    = usemodel ? qr4[0] : fq0;
   assign qsub1 = usemodel ? qm4 : fqs;
   assign q80   = qr8[0];
   assign qs81  = qm8;

   // A is one bit wider than M so the most negative multiplicand cannot overflow
   always @(posedge clk) begin
      if (cargaq) begin
         a4  <= '0;
         qm4 <= 1'b0;
         m4  <= sel ? {opm1[3], opm1} : {opm0[3], opm0};
         qr4 <= sel ? opq1 : opq0;
      end else if (cargaa) begin
         a4 <= resta ? a4 - m4 : a4 + m4;
      end else if (desplaza) begin
         {a4, qr4, qm4} <= {a4[4], a4, qr4};
      end
   end

   always @(posedge clk) begin
      if (cq8) begin
         a8  <= '0;
         qm8 <= 1'b0;
         m8  <= 9'h180;
         qr8 <= 8'hFF;
      end else if (ca8) begin
         a8 <= rs8 ? a8 - m8 : a8 + m8;
      end else if (dz8) begin
         {a8, qr8, qm8} <= {a8[8], a8, qr8};
      end
   end

   always @(negedge clk) begin
      if (gnt0 && gnt1) overlap++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs one N=4 operation for a client; request is seen at the next edge (index 1 = LOAD)
   task automatic applyStimulus(input bit cl, output int didx, output int gcnt,
                                output int scnt, output logic gafter);
      if (cl) req1 = 1'b1; else req0 = 1'b1;
      didx = 0; gcnt = 0; scnt = 0; gafter = 1'b1;
      @(posedge clk); #1;
      for (int i = 1; i <= 40; i++) begin
         if (didx != 0 && i == didx + 1) begin
            gafter = cl ? gnt1 : gnt0;
            break;
         end
         if (cl ? gnt1 : gnt0) gcnt++;
         if (desplaza) scnt++;
         if (cl ? done1 : done0) begin
            didx = i;
            if (cl) req1 = 1'b0; else req0 = 1'b0;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic waitGrant(output logic [1:0] g);
      g = 2'b00;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (gnt0 || gnt1) begin
            g = {gnt1, gnt0};
            break;
         end
      end
   endtask

   task automatic waitDone(output logic [1:0] d);
      d = 2'b00;
      for (int i = 0; i < 40; i++) begin
         if (done0 || done1) begin
            d = {done1, done0};
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   function automatic logic [11:0] outs4();
      return {gnt0, gnt1, sel, busy, cargaq, cargam, reseta, cargaa, resta, desplaza, done0, done1};
   endfunction

   initial begin
      int didx, gcnt, scnt;
      logic gafter;
      logic [1:0] g, d, p;
      logic [1:0] pats [4];
      logic [1:0] order [4];
      logic [11:0] accum;
      pats  = '{2'b00, 2'b01, 2'b10, 2'b11};
      order = '{2'b01, 2'b10, 2'b01, 2'b10};

      $display("[TB] reset state");
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_outs4", outs4(), 12'h000);
      checkOutput("reset_outs8", {g80, g81, sel8, busy8, cq8, cm8, ra8, ca8, rs8, dz8, d80, d81}, 12'h000);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      $display("[TB] single multiply client 0, 3 * -2");
      opm0 = 4'd3; opq0 = 4'hE;
      applyStimulus(1'b0, didx, gcnt, scnt, gafter);
      checkOutput("single_done_idx", didx, 10);
      checkOutput("single_gnt_cycles", gcnt, 10);
      checkOutput("single_shifts", scnt, 4);
      checkOutput("single_gnt_after", gafter, 1'b0);
      checkOutput("single_product", {a4[3:0], qr4}, 8'hFA);
      checkOutput("single_sel", sel, 1'b0);

      $display("[TB] Booth decode with forced q0/qsub1");
      @(negedge clk);
      usemodel = 1'b0;
      req0 = 1'b1;
      @(posedge clk); #1;
      for (int i = 1; i <= 10; i++) begin
         p = (i % 2 == 0 && i <= 8) ? pats[(i - 2) / 2] : 2'b10;
         fq0 = p[1]; fqs = p[0];
         #1;
         if (i % 2 == 0 && i <= 8) begin
            checkOutput($sformatf("decode_cargaa_%0d", i), cargaa, p[1] ^ p[0]);
            checkOutput($sformatf("decode_resta_%0d", i), resta, p[1] & ~p[0]);
         end else begin
            checkOutput($sformatf("decode_idle_cargaa_%0d", i), cargaa, 1'b0);
         end
         if (i == 10) begin
            checkOutput("decode_done0", done0, 1'b1);
            req0 = 1'b0;
         end
         @(posedge clk); #1;
      end
      usemodel = 1'b1;

      $display("[TB] simultaneous requests alternate");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      req0 = 1'b1; req1 = 1'b1;
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         waitGrant(g);
         checkOutput($sformatf("rr_grant_%0d", k), g, order[k]);
         waitDone(d);
         checkOutput($sformatf("rr_done_%0d", k), d, order[k]);
         if (k == 3) begin
            req0 = 1'b0; req1 = 1'b0;
         end
      end
      checkOutput("rr_no_overlap", overlap, 0);

      $display("[TB] client 1 drops request mid-operation");
      repeat (2) @(posedge clk);
      @(negedge clk);
      req1 = 1'b1;
      waitGrant(g);
      checkOutput("drop_grant1", g, 2'b10);
      repeat (2) @(posedge clk);
      #1;
      req1 = 1'b0; req0 = 1'b1;
      waitDone(d);
      checkOutput("drop_done1", d, 2'b10);
      waitGrant(g);
      checkOutput("drop_next_grant0", g, 2'b01);
      waitDone(d);
      checkOutput("drop_done0", d, 2'b01);
      req0 = 1'b0;
      repeat (2) @(posedge clk);

      $display("[TB] reset during second SHIFT");
      @(negedge clk);
      req0 = 1'b1;
      @(posedge clk); #1;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("rst_in_shift", desplaza, 1'b1);
      reset = 1'b0;
      req0 = 1'b0;
      #1;
      checkOutput("rst_outs_now", outs4(), 12'h000);
      accum = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         accum = accum | outs4();
      end
      checkOutput("rst_outs_held", accum, 12'h000);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("rst_release_idle", busy, 1'b0);
      opm1 = 4'd5; opq1 = 4'd3;
      applyStimulus(1'b1, didx, gcnt, scnt, gafter);
      checkOutput("rst_after_done_idx", didx, 10);
      checkOutput("rst_after_gnt1", gcnt, 10);
      checkOutput("rst_after_product", {a4[3:0], qr4}, 8'h0F);

      $display("[TB] N=8 multiply -128 * -1");
      @(negedge clk);
      r80 = 1'b1;
      didx = 0;
      @(posedge clk); #1;
      for (int i = 1; i <= 40; i++) begin
         if (d80) begin
            didx = i;
            r80 = 1'b0;
            break;
         end
         @(posedge clk); #1;
      end
      checkOutput("n8_done_idx", didx, 18);
      checkOutput("n8_product", {a8[7:0], qr8}, 16'h0080);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
